copies_queue: RTL and testbench

Buffered, parametrised value replicator. Each accepted input word is emitted `in_count` times on the output stream. Each successive copy is offset by a per-word `in_step`, so it can generate plain copies or arithmetic ramps. Up to `DEPTH` pending requests are queued behind the active one, so upstream is not stalled while a long run drains. It sits between two `data_interface` stream stages, as the successor to the unbuffered `copies` block, and adds queueing, stepping and a last-copy marker.

---
 rtl/copies_queue_if.sv | 14 +
 rtl/copies_queue.sv | 144 ++++++++++++++
 tb/tb_copies_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/copies_queue_if.sv
`default_nettype none
// data_interface -- valid/ack/data stream link; a transfer happens when valid && ack.
// Revision 1.0
interface data_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport producer (output valid, output data, input ack);
  modport consumer (input valid, input data, output ack);
endinterface
`default_nettype wire

// File: rtl/copies_queue.sv
`default_nettype none
// copies_queue -- replicates each accepted word in_count times, adding in_step per copy.
// Revision 1.0
module copies_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int STEP_WIDTH  = 8,
  parameter int DEPTH       = 4
) (
  input  wire logic                         clock,
  input  wire logic                         reset_n,
  input  wire logic [COUNT_WIDTH-1:0]       in_count,
  input  wire logic [STEP_WIDTH-1:0]        in_step,
  data_interface.consumer                   in,
  data_interface.producer                   out,
  output logic                              out_last,
  output logic [$clog2(DEPTH+2)-1:0]        occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [COUNT_WIDTH-1:0] count;
    logic [STEP_WIDTH-1:0]  step;
  } entry_t;

  // Active stage
  logic                   act_valid_q, act_valid_d;
  logic [DATA_WIDTH-1:0]  act_value_q, act_value_d;
  logic [STEP_WIDTH-1:0]  act_step_q, act_step_d;
  logic [COUNT_WIDTH-1:0] act_remaining_q, act_remaining_d;

  // Pending-request FIFO
  entry_t                 fifo_mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]       fifo_level_q, fifo_level_d;

  logic   in_fire;
  logic   in_take;
  logic   out_fire;
  logic   retire;
  logic   reload;
  logic   fifo_empty;
  logic   pop;
  logic   load_in;
  logic   push;
  entry_t head;
  entry_t in_entry;

  // Ack depends only on registered level, so out.ack never reaches in.ack.
  assign in.ack     = (fifo_level_q < LVL_W'(DEPTH));
  assign in_fire    = in.valid && in.ack;
  assign in_take    = in_fire && (in_count != '0);
  assign out_fire   = act_valid_q && out.ack;
  assign retire     = out_fire && (act_remaining_q == COUNT_WIDTH'(1));
  assign reload     = !act_valid_q || retire;
  assign fifo_empty = (fifo_level_q == '0);
  assign pop        = reload && !fifo_empty;
  assign load_in    = reload && fifo_empty && in_take;
  assign push       = in_take && !load_in;
  assign head       = fifo_mem[rd_ptr_q];
  assign in_entry   = '{data: in.data, count: in_count, step: in_step};

  assign out.valid  = act_valid_q;
  assign out.data   = act_value_q;
  assign out_last   = act_valid_q && (act_remaining_q == COUNT_WIDTH'(1));
  assign occupancy  = OCC_W'(act_valid_q) + OCC_W'(fifo_level_q);

  always_comb begin
    act_valid_d     = act_valid_q;
    act_value_d     = act_value_q;
    act_step_d      = act_step_q;
    act_remaining_d = act_remaining_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fifo_level_d    = fifo_level_q;

    if (reload) begin
      if (pop) begin
        act_valid_d     = 1'b1;
        act_value_d     = head.data;
        act_step_d      = head.step;
        act_remaining_d = head.count;
      end else if (load_in) begin
        act_valid_d     = 1'b1;
        act_value_d     = in.data;
        act_step_d      = in_step;
        act_remaining_d = in_count;
      end else begin
        act_valid_d     = 1'b0;
        act_remaining_d = '0;
      end
    end else if (out_fire) begin
      act_remaining_d = act_remaining_q - COUNT_WIDTH'(1);
      act_value_d     = act_value_q + DATA_WIDTH'(act_step_q);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   fifo_level_d = fifo_level_q + LVL_W'(1);
      2'b01:   fifo_level_d = fifo_level_q - LVL_W'(1);
      default: fifo_level_d = fifo_level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_valid_q     <= 1'b0;
      act_value_q     <= '0;
      act_step_q      <= '0;
      act_remaining_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      fifo_level_q    <= '0;
    end else begin
      act_valid_q     <= act_valid_d;
      act_value_q     <= act_value_d;
      act_step_q      <= act_step_d;
      act_remaining_q <= act_remaining_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fifo_level_q    <= fifo_level_d;
    end
  end

  // Storage needs no reset: entries are only read below fifo_level_q.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_entry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_copies_queue.sv
`default_nettype none
// tb_copies_queue -- directed and randomized stimulus checked against a request-level model.
// Revision 1.0
module tb_copies_queue;

  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 2);

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CW-1:0] in_count;
  logic [SW-1:0] in_step;
  logic          out_last;
  logic [OW-1:0] occupancy;

  data_interface #(.DATA_WIDTH(DW)) in_if ();
  data_interface #(.DATA_WIDTH(DW)) out_if ();

  copies_queue #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .STEP_WIDTH (SW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_count (in_count),
    .in_step  (in_step),
    .in       (in_if),
    .out      (out_if),
    .out_last (out_last),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Outstanding nonzero requests; k is the index of the copy presented for q[0].
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   cnt;
    logic [SW-1:0] st;
  } req_t;

  req_t          q[$];
  int unsigned   k;
  int            n_assert;
  int            n_fail;
  int            n_out;
  int            n_acc;
  bit            rnd_ack;
  bit            last_in_fire;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, then step past the rising edge.
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge clock);
    if (reset_n) chk("in_ack", 64'(in_if.ack), 64'(q.size() <= DEPTH));
    chk("out_valid", 64'(out_if.valid), 64'(q.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() != 0) begin
      e = q[0].d + DW'(k) * DW'(q[0].st);
      chk("out_data", 64'(out_if.data), 64'(e));
      chk("out_last", 64'(out_last), 64'(k == q[0].cnt - 1));
    end
    if (prev_stall) begin
      chk("stall_data", 64'(out_if.data), 64'(prev_data));
      chk("stall_last", 64'(out_last), 64'(prev_last));
    end
    prev_stall = out_if.valid && !out_if.ack;
    prev_data  = out_if.data;
    prev_last  = out_last;
    if (out_if.valid && out_if.ack && q.size() != 0) begin
      n_out++;
      k++;
      if (k == q[0].cnt) begin
        void'(q.pop_front());
        k = 0;
      end
    end
    last_in_fire = in_if.valid && in_if.ack;
    if (last_in_fire) begin
      n_acc++;
      if (in_count != '0) q.push_back('{d: in_if.data, cnt: 32'(in_count), st: in_step});
    end
    @(posedge clock);
    #1;
    if (rnd_ack) out_if.ack = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [DW-1:0] d, input int c, input logic [SW-1:0] s, input int lim);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_count    = CW'(c);
    in_step     = s;
    do begin
      cycle();
      n++;
    end while (!last_in_fire && n < lim);
    chk("send_accepted", 64'(last_in_fire), 64'(1));
    in_if.valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (q.size() != 0 && n < lim) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'(0));
    cycle();
  endtask

  initial begin
    int n;
    int sum;
    int out0;
    int acc0;
    int c;
    n_assert = 0; n_fail = 0; n_out = 0; n_acc = 0; k = 0;
    rnd_ack = 1'b0; prev_stall = 1'b0; last_in_fire = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    reset_n = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; in_count = '0; in_step = '0;
    out_if.ack = 1'b0;

    // Reset values
    #12;
    chk("rst_valid", 64'(out_if.valid), 64'(0));
    chk("rst_data", 64'(out_if.data), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_occ", 64'(occupancy), 64'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle();

    // Plain copies, then a wrapping ramp
    out_if.ack = 1'b1;
    send(32'h10, 3, 8'd0, 4);
    drain(20);
    send(32'hFFFF_FFFE, 4, 8'd1, 4);
    drain(20);

    // Fill to capacity with output stalled, then release
    out_if.ack = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h100 + DW'(i), 2, 8'd1, 4);
    in_if.valid = 1'b1; in_if.data = 32'h105; in_count = CW'(2); in_step = 8'd1;
    repeat (3) cycle();
    chk("full_no_accept", 64'(last_in_fire), 64'(0));
    chk("full_occ", 64'(occupancy), 64'(5));
    out_if.ack = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_in_fire && n < 10);
    chk("sixth_accept_cycle", 64'(n), 64'(3));
    in_if.valid = 1'b0;
    drain(30);

    // Counts 1,0,1: the zero-count word is acknowledged but never emitted
    acc0 = n_acc;
    out0 = n_out;
    out_if.ack = 1'b0;
    send(32'hA, 1, 8'd0, 4);
    send(32'hB, 0, 8'd0, 4);
    send(32'hC, 1, 8'd0, 4);
    chk("three_acked", 64'(n_acc - acc0), 64'(3));
    out_if.ack = 1'b1;
    drain(10);
    chk("zero_count_outputs", 64'(n_out - out0), 64'(2));

    // Random stalls and random requests
    rnd_ack = 1'b1;
    sum = 0;
    out0 = n_out;
    for (int i = 0; i < 30; i++) begin
      c = (i == 10) ? 40 : int'($urandom_range(0, 5));
      send(DW'($urandom), c, SW'($urandom), 400);
      sum += c;
      repeat ($urandom_range(0, 2)) cycle();
    end
    drain(2000);
    rnd_ack = 1'b0;
    out_if.ack = 1'b1;
    chk("total_copies", 64'(n_out - out0), 64'(sum));

    // Asynchronous reset with queued requests
    out_if.ack = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h200 + DW'(i), 3, 8'd2, 4);
    chk("pre_rst_occ", 64'(occupancy), 64'(4));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_if.valid), 64'(0));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_last", 64'(out_last), 64'(0));
    chk("arst_data", 64'(out_if.data), 64'(0));
    q.delete();
    k = 0;
    prev_stall = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_if.ack = 1'b1;
    repeat (3) cycle();
    send(32'h55, 2, 8'd3, 4);
    drain(10);

    // Long run with a large step
    send(32'hFFFF_FF00, 300, 8'hFF, 4);
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
